// File: rtl/simplez_bus_responder.sv
// Simplez bus responder: RAM plus memory-mapped screen and keyboard registers.
// Address map (default ADDRW=9): 0..507 RAM, 508 screen status,
// 509 screen data, 510 keyboard status, 511 keyboard data.
// Status words: bit0 = ready, bit1 = sticky overrun (cleared when read).
// The keyboard port is included only when SIMPLEZ_KBD_EN is defined;
// otherwise 510/511 read as zero and kbd_data/kbd_valid are ignored.
module simplez_bus_responder #(
  parameter int DATAW = 12,
  parameter int ADDRW = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADDRW-1:0] addr,
  input  logic             lec,
  input  logic             esc,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic [7:0]       scr_data,
  output logic             scr_valid,
  input  logic             scr_ready,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_valid
);

  // The four I/O registers occupy the top of the address space.
  localparam logic [ADDRW-1:0] KBD_DATA_ADDR = {ADDRW{1'b1}};
  localparam logic [ADDRW-1:0] KBD_STAT_ADDR = KBD_DATA_ADDR - ADDRW'(1);
  localparam logic [ADDRW-1:0] SCR_DATA_ADDR = KBD_DATA_ADDR - ADDRW'(2);
  localparam logic [ADDRW-1:0] SCR_STAT_ADDR = KBD_DATA_ADDR - ADDRW'(3);
  localparam int RAM_DEPTH = (1 << ADDRW) - 4;

  typedef enum logic {SCR_IDLE, SCR_SEND} scr_state_t;

  logic [DATAW-1:0] ram [RAM_DEPTH];
  logic [DATAW-1:0] rd_word;

  logic       rd_en;
  logic       is_ram;
  logic       wr_scr_data;
  logic       rd_scr_stat;
  scr_state_t scr_state;
  logic       scr_overrun;

  // A read only happens when no write is requested in the same cycle.
  assign rd_en       = lec && !esc;
  assign is_ram      = (addr < SCR_STAT_ADDR);
  assign wr_scr_data = esc && (addr == SCR_DATA_ADDR);
  assign rd_scr_stat = rd_en && (addr == SCR_STAT_ADDR);

`ifdef SIMPLEZ_KBD_EN
  typedef enum logic {KBD_EMPTY, KBD_FULL} kbd_state_t;

  kbd_state_t kbd_state;
  logic [7:0] kbd_char;
  logic       kbd_overrun;
  logic       rd_kbd_stat;
  logic       rd_kbd_data;

  assign rd_kbd_stat = rd_en && (addr == KBD_STAT_ADDR);
  assign rd_kbd_data = rd_en && (addr == KBD_DATA_ADDR);

  // Keyboard FSM: one-character buffer; a strobe coinciding with a data read
  // refills the buffer, a strobe into a full buffer is lost and flags overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kbd_state   <= KBD_EMPTY;
      kbd_char    <= 8'h00;
      kbd_overrun <= 1'b0;
    end else begin
      if (rd_kbd_stat) begin
        kbd_overrun <= 1'b0;
      end
      case (kbd_state)
        KBD_EMPTY: begin
          if (kbd_valid) begin
            kbd_char  <= kbd_data;
            kbd_state <= KBD_FULL;
          end
        end
        KBD_FULL: begin
          if (rd_kbd_data) begin
            if (kbd_valid) begin
              kbd_char <= kbd_data;
            end else begin
              kbd_state <= KBD_EMPTY;
            end
          end else if (kbd_valid) begin
            kbd_overrun <= 1'b1;
          end
        end
      endcase
    end
  end
`else
  logic kbd_unused;

  assign kbd_unused = ^{kbd_data, kbd_valid};
`endif

  // RAM write port; RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (esc && is_ram) begin
      ram[addr] <= data_in;
    end
  end

  // Read multiplexer selecting the word that a read at addr would return.
  always_comb begin
    rd_word = '0;
    if (is_ram) begin
      rd_word = ram[addr];
    end else begin
      case (addr)
        SCR_STAT_ADDR: begin
          rd_word[0] = (scr_state == SCR_IDLE);
          rd_word[1] = scr_overrun;
        end
        SCR_DATA_ADDR: begin
          rd_word[7:0] = scr_data;
        end
`ifdef SIMPLEZ_KBD_EN
        KBD_STAT_ADDR: begin
          rd_word[0] = (kbd_state == KBD_FULL);
          rd_word[1] = kbd_overrun;
        end
        KBD_DATA_ADDR: begin
          rd_word[7:0] = kbd_char;
        end
`endif
        default: rd_word = '0;
      endcase
    end
  end

  // Registered read data: loads on a read, otherwise holds its value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (rd_en) begin
      data_out <= rd_word;
    end
  end

  // Screen FSM: latches a character and holds it valid until the device
  // accepts it; writes arriving while busy are dropped and flag overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scr_state   <= SCR_IDLE;
      scr_data    <= 8'h00;
      scr_valid   <= 1'b0;
      scr_overrun <= 1'b0;
    end else begin
      if (rd_scr_stat) begin
        scr_overrun <= 1'b0;
      end
      case (scr_state)
        SCR_IDLE: begin
          if (wr_scr_data) begin
            scr_data  <= data_in[7:0];
            scr_valid <= 1'b1;
            scr_state <= SCR_SEND;
          end
        end
        SCR_SEND: begin
          if (wr_scr_data) begin
            scr_overrun <= 1'b1;
          end
          if (scr_ready) begin
            scr_valid <= 1'b0;
            scr_state <= SCR_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simplez_bus_responder.sv
// Directed testbench for simplez_bus_responder.
// Keyboard checks adapt to whether SIMPLEZ_KBD_EN is defined.
module tb_simplez_bus_responder;

  logic        clk;
  logic        rst;
  logic [8:0]  addr;
  logic        lec;
  logic        esc;
  logic [11:0] data_in;
  logic [11:0] data_out;
  logic [7:0]  scr_data;
  logic        scr_valid;
  logic        scr_ready;
  logic [7:0]  kbd_data;
  logic        kbd_valid;

  int tests_run;
  int tests_failed;

  simplez_bus_responder #(.DATAW(12), .ADDRW(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .lec       (lec),
    .esc       (esc),
    .data_in   (data_in),
    .data_out  (data_out),
    .scr_data  (scr_data),
    .scr_valid (scr_valid),
    .scr_ready (scr_ready),
    .kbd_data  (kbd_data),
    .kbd_valid (kbd_valid)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [8:0] a, input logic rd, input logic wr,
                                input logic [11:0] d);
    addr    = a;
    lec     = rd;
    esc     = wr;
    data_in = d;
    tick();
    lec = 1'b0;
    esc = 1'b0;
  endtask

  task automatic bus_write(input logic [8:0] a, input logic [11:0] d);
    apply_stimulus(a, 1'b0, 1'b1, d);
  endtask

  task automatic read_check(input string tag, input logic [8:0] a, input logic [11:0] exp);
    apply_stimulus(a, 1'b1, 1'b0, 12'h000);
    check_output(tag, {20'd0, data_out}, {20'd0, exp});
  endtask

  task automatic kbd_strobe(input logic [7:0] c);
    kbd_data  = c;
    kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
  endtask

  // Linear directed sequence.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    addr      = '0;
    lec       = 1'b0;
    esc       = 1'b0;
    data_in   = '0;
    scr_ready = 1'b0;
    kbd_data  = '0;
    kbd_valid = 1'b0;

    repeat (2) tick();
    check_output("reset_data_out", {20'd0, data_out}, 32'h000);
    check_output("reset_scr_valid", {31'd0, scr_valid}, 32'h0);
    check_output("reset_scr_data", {24'd0, scr_data}, 32'h00);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // RAM write/read, including the highest RAM word.
    bus_write(9'd5, 12'hABC);
    read_check("ram_rd_5", 9'd5, 12'hABC);
    bus_write(9'd0, 12'h5A5);
    bus_write(9'd507, 12'h123);
    read_check("ram_rd_0", 9'd0, 12'h5A5);
    read_check("ram_rd_507", 9'd507, 12'h123);

    // Write priority when lec and esc coincide: data_out holds.
    apply_stimulus(9'd6, 1'b1, 1'b1, 12'h777);
    check_output("lec_esc_hold", {20'd0, data_out}, 32'h123);
    addr = 9'd5;
    tick();
    check_output("idle_hold", {20'd0, data_out}, 32'h123);
    read_check("ram_rd_6", 9'd6, 12'h777);

    // Ignored status writes and initial screen registers.
    bus_write(9'd508, 12'hFFF);
    read_check("scr_stat_idle", 9'd508, 12'h001);
    read_check("scr_data_init", 9'd509, 12'h000);

    // Screen handshake with device stalling.
    bus_write(9'd509, 12'h041);
    check_output("scr_valid_set", {31'd0, scr_valid}, 32'h1);
    check_output("scr_data_41", {24'd0, scr_data}, 32'h41);
    read_check("scr_stat_busy", 9'd508, 12'h000);
    tick();
    check_output("scr_valid_stall", {31'd0, scr_valid}, 32'h1);
    check_output("scr_data_stall", {24'd0, scr_data}, 32'h41);
    read_check("scr_data_rd", 9'd509, 12'h041);

    // Overrun on write while busy.
    bus_write(9'd509, 12'h042);
    check_output("scr_data_kept", {24'd0, scr_data}, 32'h41);
    read_check("scr_stat_ovr", 9'd508, 12'h002);
    read_check("scr_stat_ovr_clr", 9'd508, 12'h000);

    // Device accepts.
    scr_ready = 1'b1;
    tick();
    scr_ready = 1'b0;
    check_output("scr_valid_clr", {31'd0, scr_valid}, 32'h0);
    read_check("scr_stat_ready", 9'd508, 12'h001);

`ifdef SIMPLEZ_KBD_EN
    kbd_strobe(8'h35);
    read_check("kbd_stat_full", 9'd510, 12'h001);
    read_check("kbd_data_35", 9'd511, 12'h035);
    read_check("kbd_stat_empty", 9'd510, 12'h000);
    kbd_strobe(8'h31);
    kbd_strobe(8'h32);
    read_check("kbd_stat_ovr", 9'd510, 12'h003);
    read_check("kbd_data_31", 9'd511, 12'h031);
    read_check("kbd_stat_after", 9'd510, 12'h000);
    kbd_strobe(8'h36);
    kbd_data  = 8'h37;
    kbd_valid = 1'b1;
    apply_stimulus(9'd511, 1'b1, 1'b0, 12'h000);
    kbd_valid = 1'b0;
    check_output("kbd_coincide_old", {20'd0, data_out}, 32'h036);
    read_check("kbd_coincide_stat", 9'd510, 12'h001);
    read_check("kbd_coincide_new", 9'd511, 12'h037);
    kbd_strobe(8'h38);
`else
    kbd_strobe(8'h35);
    read_check("kbd_off_stat", 9'd510, 12'h000);
    read_check("kbd_off_data", 9'd511, 12'h000);
    kbd_strobe(8'h38);
`endif

    // Reset in mid-handshake with keyboard holding a character.
    bus_write(9'd509, 12'h043);
    check_output("pre_rst_valid", {31'd0, scr_valid}, 32'h1);
    read_check("pre_rst_rd_5", 9'd5, 12'hABC);
    rst = 1'b1;
    #2;
    check_output("rst_scr_valid", {31'd0, scr_valid}, 32'h0);
    check_output("rst_scr_data", {24'd0, scr_data}, 32'h00);
    check_output("rst_data_out", {20'd0, data_out}, 32'h000);
    @(negedge clk);
    rst = 1'b0;
    tick();
    read_check("post_rst_scr_stat", 9'd508, 12'h001);
    read_check("post_rst_kbd_stat", 9'd510, 12'h000);
    read_check("post_rst_ram_5", 9'd5, 12'hABC);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
